// File: rtl/memmap_pkg.sv
// Shared types and constants for the CPU memory-map router.
package memmap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } router_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK = 32'hFFFF_C000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_0000;

  // Width of a region index; never narrower than one bit.
  function automatic int unsigned region_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memmap_router_if.sv
// CPU-side and slave-side bus signals of the memory-map router.
interface memmap_router_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGIONS = 2
);
  logic                              cpu_req;
  logic                              cpu_ready;
  logic [31:0]                       cpu_addr;
  logic                              cpu_write;
  logic [DATA_WIDTH-1:0]             cpu_wdata;
  logic                              cpu_rvalid;
  logic [DATA_WIDTH-1:0]             cpu_rdata;
  logic                              cpu_err;
  logic [NUM_REGIONS-1:0]            slv_req;
  logic [31:0]                       slv_addr;
  logic                              slv_write;
  logic [DATA_WIDTH-1:0]             slv_wdata;
  logic [NUM_REGIONS-1:0]            slv_ack;
  logic [NUM_REGIONS*DATA_WIDTH-1:0] slv_rdata;

  // Router view.
  modport slave (
    input  cpu_req, cpu_addr, cpu_write, cpu_wdata, slv_ack, slv_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
           slv_req, slv_addr, slv_write, slv_wdata
  );

  // CPU plus attached slaves view.
  modport master (
    output cpu_req, cpu_addr, cpu_write, cpu_wdata, slv_ack, slv_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
           slv_req, slv_addr, slv_write, slv_wdata
  );
endinterface

// File: rtl/memmap_addr_decoder.sv
// Combinational base/mask window decoder with lowest-index priority.
module memmap_addr_decoder
  import memmap_pkg::*;
#(
  parameter int unsigned                   NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*32-1:0]     REGION_BASE = {MMIO_BASE, BRAM_BASE},
  parameter logic [NUM_REGIONS*32-1:0]     REGION_MASK = {MMIO_MASK, BRAM_MASK},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO   = '0,
  localparam int unsigned                  IDX_W       = region_idx_width(NUM_REGIONS)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic             ro
);

  // Scan from the top index down so the lowest matching window is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ro  = 1'b0;
    for (int unsigned i = NUM_REGIONS; i > 0; i--) begin
      if ((addr & REGION_MASK[(i-1)*32 +: 32]) == REGION_BASE[(i-1)*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i - 1);
        ro  = REGION_RO[i-1];
      end
    end
  end

endmodule

// File: rtl/memmap_router.sv
// Single-outstanding CPU memory-map router: decode, forward over req/ack, respond.
module memmap_router
  import memmap_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned               NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {MMIO_BASE, BRAM_BASE},
  parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = {MMIO_MASK, BRAM_MASK},
  parameter logic [NUM_REGIONS-1:0]    REGION_RO   = '0,
  parameter int unsigned               TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memmap_router_if.slave       bus,
  output logic [15:0]          err_count
);

  localparam int unsigned IDX_W        = region_idx_width(NUM_REGIONS);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  router_state_t          state, state_n;
  logic [IDX_W-1:0]       sel, sel_n;
  logic [15:0]            timer, timer_n;
  logic [NUM_REGIONS-1:0] req, req_n;
  logic                   err_r, err_n;
  logic [DATA_WIDTH-1:0]  rdata_r, rdata_n;
  logic                   latch;
  logic [31:0]            addr_r;
  logic                   write_r;
  logic [DATA_WIDTH-1:0]  wdata_r;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_ro;

  memmap_addr_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_RO   (REGION_RO)
  ) u_decoder (
    .addr (bus.cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .ro   (dec_ro)
  );

  // Next-state and datapath updates for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    timer_n = timer;
    req_n   = req;
    err_n   = err_r;
    rdata_n = rdata_r;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          latch = 1'b1;
          if (dec_hit && !(bus.cpu_write && dec_ro)) begin
            sel_n   = dec_idx;
            timer_n = '0;
            req_n   = NUM_REGIONS'(1) << dec_idx;
            state_n = ACCESS;
          end else begin
            err_n   = 1'b1;
            rdata_n = '0;
            state_n = RESP;
          end
        end
      end
      ACCESS: begin
        // Ack is tested before the timeout so a coincident ack completes cleanly.
        if (bus.slv_ack[sel]) begin
          rdata_n = write_r ? '0 : bus.slv_rdata[sel*DATA_WIDTH +: DATA_WIDTH];
          err_n   = 1'b0;
          req_n   = '0;
          state_n = RESP;
        end else if (timer == TIMEOUT_LAST) begin
          rdata_n = '0;
          err_n   = 1'b1;
          req_n   = '0;
          state_n = RESP;
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      timer   <= '0;
      req     <= '0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      timer   <= timer_n;
      req     <= req_n;
      err_r   <= err_n;
      rdata_r <= rdata_n;
    end
  end

  // Shared slave address/write/data, held from one accept to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else if (latch) begin
      addr_r  <= bus.cpu_addr;
      write_r <= bus.cpu_write;
      wdata_r <= bus.cpu_wdata;
    end
  end

  // Saturating count of error completions, bumped once per erroring RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (state == RESP && err_r && err_count != '1) begin
      err_count <= err_count + 16'd1;
    end
  end

  assign bus.cpu_ready  = (state == IDLE);
  assign bus.cpu_rvalid = (state == RESP);
  assign bus.cpu_rdata  = (state == RESP) ? rdata_r : '0;
  assign bus.cpu_err    = (state == RESP) && err_r;
  assign bus.slv_req    = req;
  assign bus.slv_addr   = addr_r;
  assign bus.slv_write  = write_r;
  assign bus.slv_wdata  = wdata_r;

endmodule

// File: tb/tb_memmap_router.sv
// Directed bench for memmap_router: one writable/short-timeout instance, one with a read-only MMIO window.
module tb_memmap_router;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_count_a;
  logic [15:0] err_count_b;
  int          errors = 0;
  int          checks = 0;

  memmap_router_if #(.DATA_WIDTH(32), .NUM_REGIONS(2)) bus_a ();
  memmap_router_if #(.DATA_WIDTH(32), .NUM_REGIONS(2)) bus_b ();

  memmap_router #(
    .DATA_WIDTH  (32),
    .NUM_REGIONS (2),
    .REGION_BASE ({32'hFFFF0000, 32'h00000000}),
    .REGION_MASK ({32'hFFFF0000, 32'hFFFFC000}),
    .REGION_RO   (2'b00),
    .TIMEOUT     (4)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .err_count (err_count_a)
  );

  memmap_router #(
    .DATA_WIDTH  (32),
    .NUM_REGIONS (2),
    .REGION_BASE ({32'hFFFF0000, 32'h00000000}),
    .REGION_MASK ({32'hFFFF0000, 32'hFFFFC000}),
    .REGION_RO   (2'b10),
    .TIMEOUT     (255)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .err_count (err_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.cpu_req = 1'b0; bus_a.cpu_addr = '0; bus_a.cpu_write = 1'b0; bus_a.cpu_wdata = '0;
    bus_a.slv_ack = '0;   bus_a.slv_rdata = '0;
    bus_b.cpu_req = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_write = 1'b0; bus_b.cpu_wdata = '0;
    bus_b.slv_ack = '0;   bus_b.slv_rdata = '0;
    step(); step();

    // Reset state
    check("rst_ready",  bus_a.cpu_ready, 1);
    check("rst_req",    bus_a.slv_req, 0);
    check("rst_rvalid", bus_a.cpu_rvalid, 0);
    check("rst_err",    bus_a.cpu_err, 0);
    check("rst_rdata",  bus_a.cpu_rdata, 0);
    check("rst_saddr",  bus_a.slv_addr, 0);
    check("rst_ecnt",   err_count_a, 0);
    check("rst_ecnt_b", err_count_b, 0);
    rst_n = 1'b1;
    step();

    // 1: zero-wait read from BRAM window
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h0000_0010; bus_a.cpu_write = 1'b0;
    check("t1_ready", bus_a.cpu_ready, 1);
    step();
    bus_a.cpu_req = 1'b0;
    check("t1_req",    bus_a.slv_req, 2'b01);
    check("t1_saddr",  bus_a.slv_addr, 32'h0000_0010);
    check("t1_swrite", bus_a.slv_write, 0);
    check("t1_rv0",    bus_a.cpu_rvalid, 0);
    bus_a.slv_ack = 2'b01; bus_a.slv_rdata = {32'h0, 32'hDEADBEEF};
    step();
    bus_a.slv_ack = 2'b00;
    check("t1_req_off", bus_a.slv_req, 0);
    check("t1_rvalid",  bus_a.cpu_rvalid, 1);
    check("t1_rdata",   bus_a.cpu_rdata, 32'hDEADBEEF);
    check("t1_err",     bus_a.cpu_err, 0);
    step();
    check("t1_rv_pulse", bus_a.cpu_rvalid, 0);
    check("t1_rdata_0",  bus_a.cpu_rdata, 0);
    check("t1_ready2",   bus_a.cpu_ready, 1);

    // 2: MMIO write, ack on 4th ACCESS cycle (coincides with timeout of 4), stray ack from slave0
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'hFFFF_0004; bus_a.cpu_write = 1'b1; bus_a.cpu_wdata = 32'h55;
    step();
    bus_a.cpu_req = 1'b0; bus_a.cpu_wdata = 32'hAA;
    check("t2_req_c1", bus_a.slv_req, 2'b10);
    step();
    check("t2_req_c2", bus_a.slv_req, 2'b10);
    bus_a.slv_ack = 2'b01; bus_a.slv_rdata = {32'h1234_5678, 32'h9999_9999};
    step();
    bus_a.slv_ack = 2'b00;
    check("t2_req_c3",  bus_a.slv_req, 2'b10);
    check("t2_rv_c3",   bus_a.cpu_rvalid, 0);
    step();
    check("t2_req_c4",  bus_a.slv_req, 2'b10);
    check("t2_wdata",   bus_a.slv_wdata, 32'h55);
    check("t2_swrite",  bus_a.slv_write, 1);
    check("t2_saddr",   bus_a.slv_addr, 32'hFFFF_0004);
    bus_a.slv_ack = 2'b10;
    step();
    bus_a.slv_ack = 2'b00;
    check("t2_rvalid", bus_a.cpu_rvalid, 1);
    check("t2_err",    bus_a.cpu_err, 0);
    check("t2_rdata",  bus_a.cpu_rdata, 0);
    check("t2_req_off", bus_a.slv_req, 0);
    step();
    check("t2_ecnt", err_count_a, 0);

    // 3: unmapped read
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h8000_0000; bus_a.cpu_write = 1'b0;
    step();
    bus_a.cpu_req = 1'b0;
    check("t3_rvalid", bus_a.cpu_rvalid, 1);
    check("t3_err",    bus_a.cpu_err, 1);
    check("t3_rdata",  bus_a.cpu_rdata, 0);
    check("t3_noreq",  bus_a.slv_req, 0);
    check("t3_saddr",  bus_a.slv_addr, 32'h8000_0000);
    step();
    check("t3_ecnt",   err_count_a, 1);
    check("t3_rv_off", bus_a.cpu_rvalid, 0);

    // 4: timeout after 4 ACCESS cycles, then late ack ignored
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h0000_0020;
    step();
    bus_a.cpu_req = 1'b0;
    check("t4_req_c1", bus_a.slv_req, 2'b01);
    step();
    check("t4_req_c2", bus_a.slv_req, 2'b01);
    step();
    check("t4_req_c3", bus_a.slv_req, 2'b01);
    step();
    check("t4_req_c4", bus_a.slv_req, 2'b01);
    check("t4_rv_c4",  bus_a.cpu_rvalid, 0);
    step();
    check("t4_req_off", bus_a.slv_req, 0);
    check("t4_rvalid",  bus_a.cpu_rvalid, 1);
    check("t4_err",     bus_a.cpu_err, 1);
    check("t4_rdata",   bus_a.cpu_rdata, 0);
    bus_a.slv_ack = 2'b01; bus_a.slv_rdata = {32'h0, 32'hBAD0BAD0};
    step();
    check("t4_idle",  bus_a.cpu_ready, 1);
    check("t4_rv_off", bus_a.cpu_rvalid, 0);
    check("t4_ecnt",  err_count_a, 2);
    step();
    bus_a.slv_ack = 2'b00;
    check("t4_idle_ack_ready", bus_a.cpu_ready, 1);
    check("t4_idle_ack_req",   bus_a.slv_req, 0);
    check("t4_idle_ack_rv",    bus_a.cpu_rvalid, 0);

    // 5: write to read-only MMIO region, then read the same address
    bus_b.cpu_req = 1'b1; bus_b.cpu_addr = 32'hFFFF_0000; bus_b.cpu_write = 1'b1; bus_b.cpu_wdata = 32'h77;
    step();
    bus_b.cpu_req = 1'b0;
    check("t5_rvalid", bus_b.cpu_rvalid, 1);
    check("t5_err",    bus_b.cpu_err, 1);
    check("t5_noreq",  bus_b.slv_req, 0);
    step();
    check("t5_ecnt",  err_count_b, 1);
    bus_b.cpu_req = 1'b1; bus_b.cpu_write = 1'b0;
    step();
    bus_b.cpu_req = 1'b0;
    check("t5_rd_req", bus_b.slv_req, 2'b10);
    bus_b.slv_ack = 2'b10; bus_b.slv_rdata = {32'hCAFE_0001, 32'h0};
    step();
    bus_b.slv_ack = 2'b00;
    check("t5_rd_rvalid", bus_b.cpu_rvalid, 1);
    check("t5_rd_err",    bus_b.cpu_err, 0);
    check("t5_rd_rdata",  bus_b.cpu_rdata, 32'hCAFE_0001);

    // 6: asynchronous reset mid-ACCESS, then back-to-back reads
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h0000_0040; bus_a.cpu_write = 1'b0;
    step();
    bus_a.cpu_req = 1'b0;
    check("t6_req_pre", bus_a.slv_req, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_req",   bus_a.slv_req, 0);
    check("t6_rst_rv",    bus_a.cpu_rvalid, 0);
    check("t6_rst_ecnt",  err_count_a, 0);
    check("t6_rst_ready", bus_a.cpu_ready, 1);
    #2 rst_n = 1'b1;
    step();
    check("t6_ready", bus_a.cpu_ready, 1);
    check("t6_req0",  bus_a.slv_req, 0);
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h0000_0100;
    step();
    check("t6_b1_req", bus_a.slv_req, 2'b01);
    bus_a.cpu_addr = 32'hFFFF_0008;
    bus_a.slv_ack = 2'b01; bus_a.slv_rdata = {32'h0, 32'h1111_1111};
    step();
    bus_a.slv_ack = 2'b00;
    check("t6_b1_rvalid", bus_a.cpu_rvalid, 1);
    check("t6_b1_rdata",  bus_a.cpu_rdata, 32'h1111_1111);
    check("t6_b1_busy",   bus_a.cpu_ready, 0);
    step();
    check("t6_b2_ready", bus_a.cpu_ready, 1);
    step();
    bus_a.cpu_req = 1'b0;
    check("t6_b2_req",   bus_a.slv_req, 2'b10);
    check("t6_b2_saddr", bus_a.slv_addr, 32'hFFFF_0008);
    bus_a.slv_ack = 2'b10; bus_a.slv_rdata = {32'h2222_2222, 32'h0};
    step();
    bus_a.slv_ack = 2'b00;
    check("t6_b2_rvalid", bus_a.cpu_rvalid, 1);
    check("t6_b2_rdata",  bus_a.cpu_rdata, 32'h2222_2222);
    check("t6_b2_err",    bus_a.cpu_err, 0);
    step();
    check("t6_ecnt", err_count_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
